alu_slice_seq: RTL

Parametrised, multi-cycle successor to the SM83 8-bit ALU. It executes arithmetic and logic ops on WIDTH-bit operands slice-serially, SLICE bits per cycle, with the carry held in a register between slices. It also executes shift/rotate ops in a single whole-width cycle, and it owns the Z/N/H/C flag register and the condition-code check. It sits between the register-file read ports and the writeback bus, uses a valid/ready handshake on both sides, and replaces the fixed 8-bit datapath plus the separate flag latches.

---
 rtl/alu_seq_pkg.sv | 92 +++++++++
 rtl/alu_slice.sv | 48 ++++
 rtl/alu_slice_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Opcodes, flag/cc encodings and op-class helpers for alu_slice_seq
// Revision : 1.0
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_SBC = 5'd3,
    OP_CP   = 5'd4,  OP_AND = 5'd5,  OP_XOR = 5'd6,  OP_OR  = 5'd7,
    OP_INC  = 5'd8,  OP_DEC = 5'd9,  OP_RLC = 5'd10, OP_RRC = 5'd11,
    OP_RL   = 5'd12, OP_RR  = 5'd13, OP_SLA = 5'd14, OP_SRA = 5'd15,
    OP_SRL  = 5'd16, OP_SWAP = 5'd17
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] CC_NZ = 2'b00;
  localparam logic [1:0] CC_Z  = 2'b01;
  localparam logic [1:0] CC_NC = 2'b10;
  localparam logic [1:0] CC_C  = 2'b11;

  localparam int SHIFT_MAXW = 64;

  typedef enum logic [2:0] {SC_ADD, SC_SUB, SC_AND, SC_XOR, SC_OR} slice_cls_e;

  function automatic logic is_sub(input logic [4:0] op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP) || (op == OP_DEC);
  endfunction

  function automatic logic is_alu(input logic [4:0] op);
    return op <= 5'(OP_DEC);
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return (op >= 5'(OP_RLC)) && (op <= 5'(OP_SWAP));
  endfunction

  // INC/DEC keep the carry flag
  function automatic logic writes_c(input logic [4:0] op);
    return is_alu(op) && (op != OP_INC) && (op != OP_DEC);
  endfunction

  function automatic slice_cls_e slice_cls(input logic [4:0] op);
    case (op)
      OP_AND:  return SC_AND;
      OP_XOR:  return SC_XOR;
      OP_OR:   return SC_OR;
      default: return is_sub(op) ? SC_SUB : SC_ADD;
    endcase
  endfunction

  // Whole-width shift/rotate on the low w bits; returns {carry, result}
  function automatic logic [SHIFT_MAXW:0] shift_rot(input logic [4:0] op,
                                                   input logic [SHIFT_MAXW-1:0] a,
                                                   input int unsigned w,
                                                   input logic fc);
    logic [SHIFT_MAXW-1:0] mask;
    logic [SHIFT_MAXW-1:0] top;
    logic [SHIFT_MAXW-1:0] res;
    logic msb;
    logic lsb;
    logic c;
    mask = {SHIFT_MAXW{1'b1}} >> (SHIFT_MAXW - w);
    top  = SHIFT_MAXW'(1) << (w - 1);
    msb  = |(a & top);
    lsb  = a[0];
    c    = fc;
    res  = a;
    case (op)
      OP_RLC:  begin res = (a << 1) | SHIFT_MAXW'(msb);  c = msb; end
      OP_RRC:  begin res = (a >> 1) | (lsb ? top : '0);  c = lsb; end
      OP_RL:   begin res = (a << 1) | SHIFT_MAXW'(fc);   c = msb; end
      OP_RR:   begin res = (a >> 1) | (fc ? top : '0);   c = lsb; end
      OP_SLA:  begin res = a << 1;                        c = msb; end
      OP_SRA:  begin res = (a >> 1) | (msb ? top : '0);  c = lsb; end
      OP_SRL:  begin res = a >> 1;                        c = lsb; end
      OP_SWAP: begin
        res = ((a & {(SHIFT_MAXW/8){8'h0F}}) << 4) | ((a & {(SHIFT_MAXW/8){8'hF0}}) >> 4);
        c   = 1'b0;
      end
      default: ;
    endcase
    return {c, res & mask};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice
// Purpose  : Combinational SLICE-bit add/sub/logic cell with internal carry tap
// Revision : 1.0
// ============================================================================
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int SLICE = 8,
  parameter int TW    = (SLICE > 1) ? $clog2(SLICE) : 1
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  input  slice_cls_e       i_cls,
  input  logic [TW-1:0]    i_tap,
  output logic [SLICE-1:0] o_res,
  output logic             o_cout,
  output logic             o_tap
);

  logic [SLICE-1:0] w_b;
  logic [SLICE-1:0] w_sum;
  logic             w_c;

  // Carries stay in true-carry polarity; subtraction only inverts b here
  always_comb begin
    w_b    = (i_cls == SC_SUB) ? ~i_b : i_b;
    w_sum  = '0;
    w_c    = i_cin;
    o_tap  = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      w_sum[i] = i_a[i] ^ w_b[i] ^ w_c;
      w_c      = (i_a[i] & w_b[i]) | (i_a[i] & w_c) | (w_b[i] & w_c);
      if (i == int'(i_tap)) o_tap = w_c;
    end
    o_cout = w_c;
    case (i_cls)
      SC_AND:  o_res = i_a & i_b;
      SC_XOR:  o_res = i_a ^ i_b;
      SC_OR:   o_res = i_a | i_b;
      default: o_res = w_sum;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_slice_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice_seq
// Purpose  : Slice-serial ALU with flag register, cc check and valid/ready I/O
// Revision : 1.0
// ============================================================================
module alu_slice_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [3:0]       flags,
  input  logic             flag_ld,
  input  logic [3:0]       flag_din,
  input  logic [1:0]       cc,
  output logic             cc_true
);

  localparam int NS      = WIDTH / SLICE;
  localparam int SW      = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW      = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam int H_SLICE = (WIDTH - 5) / SLICE;
  localparam int H_LOCAL = (WIDTH - 5) % SLICE;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_e;

  state_e           r_state, w_state_next;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a, r_a_sh, r_b_sh, r_res;
  logic [3:0]       r_flags;
  logic [SW-1:0]    r_slice;
  logic             r_carry, r_zacc, r_h;

  logic [SLICE-1:0]      w_sres;
  logic                  w_cout, w_tap, w_h_raw, w_z, w_last;
  logic                  w_cin_raw;
  logic [WIDTH-1:0]      w_res_next, w_res_final;
  logic [3:0]            w_flags_next;
  logic [SHIFT_MAXW:0]   w_shv;
  logic                  w_unused_sh;

  alu_slice #(.SLICE(SLICE), .TW(TW)) u_slice (
    .i_a    (r_a_sh[SLICE-1:0]),
    .i_b    (r_b_sh[SLICE-1:0]),
    .i_cin  (r_carry),
    .i_cls  (slice_cls(r_op)),
    .i_tap  (TW'(H_LOCAL)),
    .o_res  (w_sres),
    .o_cout (w_cout),
    .o_tap  (w_tap)
  );

  assign w_shv       = shift_rot(r_op, SHIFT_MAXW'(r_a), WIDTH, r_flags[FLAG_C]);
  assign w_unused_sh = ^w_shv[SHIFT_MAXW-1:WIDTH];

  assign w_last     = (r_state == ST_EXEC) && (!is_alu(r_op) || (r_slice == SW'(NS - 1)));
  assign w_h_raw    = (r_slice == SW'(H_SLICE)) ? w_tap : r_h;
  assign w_z        = r_zacc & (w_sres == '0);
  // New slice enters at the top; after NS slices the result is aligned
  assign w_res_next = (r_res >> SLICE) | (WIDTH'(w_sres) << (WIDTH - SLICE));
  assign w_cin_raw  = ((req_op == OP_ADC) || (req_op == OP_SBC)) ? r_flags[FLAG_C]
                                                                   : (req_op == OP_INC);

  always_comb begin
    w_flags_next = r_flags;
    w_res_final  = r_a;
    if (is_shift(r_op)) begin
      w_res_final          = w_shv[WIDTH-1:0];
      w_flags_next[FLAG_Z] = (w_shv[WIDTH-1:0] == '0);
      w_flags_next[FLAG_N] = 1'b0;
      w_flags_next[FLAG_H] = 1'b0;
      w_flags_next[FLAG_C] = w_shv[SHIFT_MAXW];
    end else if (is_alu(r_op)) begin
      w_res_final          = (r_op == OP_CP) ? r_a : w_res_next;
      w_flags_next[FLAG_Z] = w_z;
      w_flags_next[FLAG_N] = is_sub(r_op);
      case (slice_cls(r_op))
        SC_AND:         w_flags_next[FLAG_H] = 1'b1;
        SC_XOR, SC_OR:  w_flags_next[FLAG_H] = 1'b0;
        default:        w_flags_next[FLAG_H] = is_sub(r_op) ? ~w_h_raw : w_h_raw;
      endcase
      if (writes_c(r_op)) begin
        if (slice_cls(r_op) == SC_ADD || slice_cls(r_op) == SC_SUB)
          w_flags_next[FLAG_C] = is_sub(r_op) ? ~w_cout : w_cout;
        else
          w_flags_next[FLAG_C] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = ST_EXEC;
      ST_EXEC: if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_op    <= '0;
      r_a     <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_slice <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_h     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_op    <= req_op;
          r_a     <= req_a;
          r_a_sh  <= req_a;
          r_b_sh  <= (req_op == OP_INC) ? '0 : (req_op == OP_DEC) ? WIDTH'(1) : req_b;
          r_slice <= '0;
          r_carry <= is_sub(req_op) ? ~w_cin_raw : w_cin_raw;
          r_zacc  <= 1'b1;
          r_h     <= 1'b0;
        end
        ST_EXEC: begin
          r_carry <= w_cout;
          r_zacc  <= w_z;
          r_h     <= w_h_raw;
          r_a_sh  <= r_a_sh >> SLICE;
          r_b_sh  <= r_b_sh >> SLICE;
          if (w_last) begin
            r_res <= w_res_final;
          end else begin
            r_res   <= w_res_next;
            r_slice <= r_slice + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Completion has priority; a coincident flag_ld is dropped
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)      r_flags <= 4'b0000;
    else if (w_last)  r_flags <= w_flags_next;
    else if (flag_ld) r_flags <= flag_din;
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_res   = r_res;
  assign flags     = r_flags;
  assign cc_true   = ((cc == CC_NZ) & ~r_flags[FLAG_Z]) | ((cc == CC_Z) & r_flags[FLAG_Z]) |
                     ((cc == CC_NC) & ~r_flags[FLAG_C]) | ((cc == CC_C) & r_flags[FLAG_C]);

endmodule
`default_nettype wire
